// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_pkg
//  Description : Shared types, default timing constants and helper functions
//                for the push-button debounce block.
//  Revision    : 1.0  initial release
// ============================================================================
package key_pkg;

    // Per-channel debounce/hold state
    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_PRESS_WAIT   = 3'd1,
        ST_PRESSED      = 3'd2,
        ST_HELD         = 3'd3,
        ST_RELEASE_WAIT = 3'd4
    } key_state_t;

    localparam int DEF_N_KEYS      = 5;
    localparam int DEF_CLK_HZ      = 100_000_000;
    localparam int DEF_DEBOUNCE_MS = 20;
    localparam int DEF_LONG_MS     = 1000;
    localparam int DEF_REPEAT_MS   = 200;

    // Bits needed to hold any value in 0..max_val
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage : key_pkg
`default_nettype wire

// File: rtl/key_channel.sv
`default_nettype none
// ============================================================================
//  Module      : key_channel
//  Description : One key: 2-FF synchronizer, debounce/hold FSM with saturating
//                debounce and hold counters, registered level and strobes.
//  Revision    : 1.0  initial release
// ============================================================================
module key_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS,
    parameter int LONG_MS     = DEF_LONG_MS,
    parameter int REPEAT_MS   = DEF_REPEAT_MS
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long,
    output logic key_repeat
);

    localparam int CW = cnt_width(max3(DEBOUNCE_MS, LONG_MS, REPEAT_MS));

    // Each "reaches N" condition is detected on the tick that would make the
    // counter equal N, so the transition happens on exactly the N-th tick.
    localparam logic [CW-1:0] c_DEB_LAST  = CW'(DEBOUNCE_MS - 1);
    localparam logic [CW-1:0] c_LONG_LAST = CW'(LONG_MS - 1);
    localparam logic [CW-1:0] c_REP_LAST  = CW'(REPEAT_MS - 1);
    localparam logic [CW-1:0] c_ONE       = CW'(1);

    logic            r_sync1;
    logic            r_sync2;
    logic            w_key_s;
    key_state_t      r_state;
    logic [CW-1:0]   r_dcnt;
    logic [CW-1:0]   r_hcnt;
    logic            r_from_held;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == '1) ? v : v + c_ONE;
    endfunction

    // Two-flop synchronizer for the asynchronous pad input
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= key_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_key_s = r_sync2;

    // Debounce/hold FSM with registered level and one-cycle strobes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_dcnt      <= '0;
            r_hcnt      <= '0;
            r_from_held <= 1'b0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            key_repeat  <= 1'b0;
        end else begin
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
            key_repeat  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_key_s) begin
                        r_state <= ST_PRESS_WAIT;
                        r_dcnt  <= '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!w_key_s) begin
                        r_state <= ST_IDLE;
                    end else if (tick) begin
                        if (r_dcnt == c_DEB_LAST) begin
                            r_state   <= ST_PRESSED;
                            key_level <= 1'b1;
                            key_press <= 1'b1;
                            r_hcnt    <= '0;
                        end else begin
                            r_dcnt <= sat_inc(r_dcnt);
                        end
                    end
                end
                ST_PRESSED: begin
                    if (!w_key_s) begin
                        r_state     <= ST_RELEASE_WAIT;
                        r_dcnt      <= '0;
                        r_from_held <= 1'b0;
                    end else if (tick) begin
                        if (r_hcnt == c_LONG_LAST) begin
                            key_long <= 1'b1;
                            r_state  <= ST_HELD;
                            r_hcnt   <= '0;
                        end else begin
                            r_hcnt <= sat_inc(r_hcnt);
                        end
                    end
                end
                ST_HELD: begin
                    if (!w_key_s) begin
                        r_state     <= ST_RELEASE_WAIT;
                        r_dcnt      <= '0;
                        r_from_held <= 1'b1;
                    end else if (tick) begin
                        if (r_hcnt == c_REP_LAST) begin
                            key_repeat <= 1'b1;
                            r_hcnt     <= '0;
                        end else begin
                            r_hcnt <= sat_inc(r_hcnt);
                        end
                    end
                end
                ST_RELEASE_WAIT: begin
                    // Hold counter is frozen here so a short dropout resumes it
                    if (w_key_s) begin
                        r_state <= r_from_held ? ST_HELD : ST_PRESSED;
                    end else if (tick) begin
                        if (r_dcnt == c_DEB_LAST) begin
                            r_state     <= ST_IDLE;
                            key_level   <= 1'b0;
                            key_release <= 1'b1;
                        end else begin
                            r_dcnt <= sat_inc(r_dcnt);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : key_channel
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Shared 1 ms tick prescaler feeding N_KEYS independent
//                debounce channels (level, press, release, long, repeat).
//  Revision    : 1.0  initial release
// ============================================================================
module key_debounce
    import key_pkg::*;
#(
    parameter int N_KEYS      = DEF_N_KEYS,
    parameter int CLK_HZ      = DEF_CLK_HZ,
    parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS,
    parameter int LONG_MS     = DEF_LONG_MS,
    parameter int REPEAT_MS   = DEF_REPEAT_MS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic [N_KEYS-1:0] key_long,
    output logic [N_KEYS-1:0] key_repeat
);

    localparam int PS_DIV = CLK_HZ / 1000;
    localparam int PW     = cnt_width(PS_DIV - 1);

    localparam logic [PW-1:0] c_PS_LAST = PW'(PS_DIV - 1);
    localparam logic [PW-1:0] c_PS_ONE  = PW'(1);

    logic [PW-1:0] r_ps;
    logic          r_tick;

    // 1 ms prescaler: tick pulses for one cycle each time the count wraps
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ps   <= '0;
            r_tick <= 1'b0;
        end else if (r_ps == c_PS_LAST) begin
            r_ps   <= '0;
            r_tick <= 1'b1;
        end else begin
            r_ps   <= r_ps + c_PS_ONE;
            r_tick <= 1'b0;
        end
    end

    generate
        for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
            key_channel #(
                .DEBOUNCE_MS (DEBOUNCE_MS),
                .LONG_MS     (LONG_MS),
                .REPEAT_MS   (REPEAT_MS)
            ) u_chan (
                .clk         (clk),
                .rst         (rst),
                .tick        (r_tick),
                .key_in      (key_in[i]),
                .key_level   (key_level[i]),
                .key_press   (key_press[i]),
                .key_release (key_release[i]),
                .key_long    (key_long[i]),
                .key_repeat  (key_repeat[i])
            );
        end
    endgenerate

endmodule : key_debounce
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_debounce
//  Description : Self-checking bench for key_debounce. Every strobe the DUT
//                emits is logged; expected strobes with cycle windows are
//                queued as stimulus is applied and matched against the log.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_key_debounce;

    // Prescaler divides by 10 here so the second-scale sequences stay short
    localparam int TB_CLK_HZ = 10_000;
    localparam int T         = TB_CLK_HZ / 1000;
    localparam int NK        = 5;
    localparam int DEB       = 20;
    localparam int LONG      = 1000;
    localparam int REP       = 200;

    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_LONG    = 2;
    localparam int K_REPEAT  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] key_in = '0;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic [NK-1:0] key_long;
    logic [NK-1:0] key_repeat;

    int cyc    = 0;
    int n_cmp  = 0;
    int n_bad  = 0;
    int n_coin = 0;

    typedef struct { int cyc; int kind; int key; } ev_t;
    typedef struct { int kind; int key; int lo; int hi; } exp_t;
    typedef struct { int key; int width_ms; int gap_ms; bit exp_press; bit exp_long; int exp_reps; } vec_t;

    ev_t  obs_q[$];
    exp_t exp_q[$];
    vec_t vecs[5];

    key_debounce #(
        .N_KEYS      (NK),
        .CLK_HZ      (TB_CLK_HZ),
        .DEBOUNCE_MS (DEB),
        .LONG_MS     (LONG),
        .REPEAT_MS   (REP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_in      (key_in),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long),
        .key_repeat  (key_repeat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every strobe observed between clock edges
    always @(negedge clk) begin
        for (int k = 0; k < NK; k++) begin
            if (key_press[k] === 1'b1)   obs_q.push_back('{cyc, K_PRESS, k});
            if (key_release[k] === 1'b1) obs_q.push_back('{cyc, K_RELEASE, k});
            if (key_long[k] === 1'b1)    obs_q.push_back('{cyc, K_LONG, k});
            if (key_repeat[k] === 1'b1)  obs_q.push_back('{cyc, K_REPEAT, k});
            if (key_press[k] === 1'b1 && key_release[k] === 1'b1) n_coin++;
        end
    end

    initial begin
        #(90_000 * 10);
        $display("FAIL watchdog: simulation still running at cycle %0d, required finish earlier", cyc);
        $fatal(1, "watchdog");
    end

    function automatic string kname(input int k);
        case (k)
            K_PRESS:   return "press";
            K_RELEASE: return "release";
            K_LONG:    return "long";
            default:   return "repeat";
        endcase
    endfunction

    // Queue one expected strobe; off_ticks is the distance in ticks from
    // the accepted press (0 for press/release themselves).
    task automatic push_exp(input int kind, input int key, input int base, input int off_ticks);
        exp_q.push_back('{kind, key, base + (DEB - 1 + off_ticks) * T, base + (DEB + off_ticks) * T + 5});
    endtask

    task automatic wait_ms(input int ms);
        repeat (ms * T) @(negedge clk);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, required %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_vec(input string name, input logic [NK-1:0] act, input logic [NK-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, required %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Match each expected strobe to one logged strobe inside its window,
    // then require the log to be empty (no extra or repeated strobes).
    task automatic check_events(input string tag);
        foreach (exp_q[i]) begin
            int hit;
            hit = -1;
            for (int j = 0; j < obs_q.size(); j++) begin
                if (hit < 0 && obs_q[j].kind == exp_q[i].kind && obs_q[j].key == exp_q[i].key &&
                    obs_q[j].cyc >= exp_q[i].lo && obs_q[j].cyc <= exp_q[i].hi)
                    hit = j;
            end
            n_cmp++;
            if (hit < 0) begin
                n_bad++;
                $display("FAIL %s %s[%0d]: got no strobe in cycles %0d..%0d, required one",
                         tag, kname(exp_q[i].kind), exp_q[i].key, exp_q[i].lo, exp_q[i].hi);
            end else begin
                obs_q.delete(hit);
            end
        end
        exp_q.delete();
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s extra strobes: got %0d, required 0 (first %s[%0d] at cycle %0d)",
                     tag, obs_q.size(), kname(obs_q[0].kind), obs_q[0].key, obs_q[0].cyc);
        end
        obs_q.delete();
    endtask

    initial begin
        int c;
        int c2;
        int waited;

        // {key, width_ms, gap_ms, press, long, repeats}
        vecs[0] = '{0,   30, 40, 1'b1, 1'b0, 0};  // clean press
        vecs[1] = '{2,   18, 40, 1'b0, 1'b0, 0};  // glitch just under the window
        vecs[2] = '{1,    5, 40, 1'b0, 1'b0, 0};  // short glitch
        vecs[3] = '{2, 1500, 40, 1'b1, 1'b1, 2};  // long press with two repeats
        vecs[4] = '{3,   25, 40, 1'b1, 1'b0, 0};  // press just past the window

        // Reset state
        repeat (5) @(negedge clk);
        check_vec("reset level",   key_level,   '0);
        check_vec("reset press",   key_press,   '0);
        check_vec("reset release", key_release, '0);
        check_vec("reset long",    key_long,    '0);
        check_vec("reset repeat",  key_repeat,  '0);
        rst = 1'b0;
        obs_q.delete();
        repeat (3) @(negedge clk);

        // Table-driven single-key pulses
        for (int v = 0; v < 5; v++) begin
            c = cyc;
            key_in[vecs[v].key] = 1'b1;
            if (vecs[v].exp_press) push_exp(K_PRESS, vecs[v].key, c, 0);
            if (vecs[v].exp_long)  push_exp(K_LONG,  vecs[v].key, c, LONG);
            for (int r = 1; r <= vecs[v].exp_reps; r++)
                push_exp(K_REPEAT, vecs[v].key, c, LONG + r * REP);
            wait_ms(vecs[v].width_ms);
            check_bit($sformatf("vec%0d level while held", v), key_level[vecs[v].key], vecs[v].exp_press);
            c2 = cyc;
            key_in[vecs[v].key] = 1'b0;
            if (vecs[v].exp_press) push_exp(K_RELEASE, vecs[v].key, c2, 0);
            wait_ms(vecs[v].gap_ms);
            check_bit($sformatf("vec%0d level after gap", v), key_level[vecs[v].key], 1'b0);
            check_events($sformatf("vec%0d", v));
        end

        // Bounce on key 1: 3 ms toggles, final rising edge at 12 ms
        for (int i = 0; i < 4; i++) begin
            key_in[1] = (i % 2 == 0);
            wait_ms(3);
        end
        c = cyc;
        key_in[1] = 1'b1;
        push_exp(K_PRESS, 1, c, 0);
        wait_ms(43);
        check_bit("bounce level", key_level[1], 1'b1);
        c2 = cyc;
        key_in[1] = 1'b0;
        push_exp(K_RELEASE, 1, c2, 0);
        wait_ms(40);
        check_events("bounce");

        // Key 3 dropout of 2 ms during a hold, alongside an 18 ms pulse on key 2
        c = cyc;
        key_in[3] = 1'b1;
        push_exp(K_PRESS, 3, c, 0);
        wait_ms(40);
        key_in[3] = 1'b0;
        key_in[2] = 1'b1;
        wait_ms(2);
        key_in[3] = 1'b1;
        wait_ms(16);
        key_in[2] = 1'b0;
        wait_ms(20);
        check_bit("dropout level", key_level[3], 1'b1);
        c2 = cyc;
        key_in[3] = 1'b0;
        push_exp(K_RELEASE, 3, c2, 0);
        wait_ms(40);
        check_events("dropout");

        // Simultaneous press on keys 3 and 4
        c = cyc;
        key_in[3] = 1'b1;
        key_in[4] = 1'b1;
        push_exp(K_PRESS, 3, c, 0);
        push_exp(K_PRESS, 4, c, 0);
        waited = 0;
        while (key_press[3] !== 1'b1 && waited < (DEB + 2) * T) begin
            @(negedge clk);
            waited++;
        end
        if (key_press[3] === 1'b1) begin
            check_bit("simultaneous press[4]", key_press[4], 1'b1);
        end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL simultaneous press[3]: got none within %0d cycles, required one", waited);
        end
        wait_ms(20);
        c2 = cyc;
        key_in[3] = 1'b0;
        key_in[4] = 1'b0;
        push_exp(K_RELEASE, 3, c2, 0);
        push_exp(K_RELEASE, 4, c2, 0);
        wait_ms(40);
        check_events("simultaneous");

        // Reset while key 0 is in the held state
        c = cyc;
        key_in[0] = 1'b1;
        push_exp(K_PRESS, 0, c, 0);
        push_exp(K_LONG,  0, c, LONG);
        wait_ms(1100);
        check_bit("held level before reset", key_level[0], 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_vec("mid reset level",   key_level,   '0);
        check_vec("mid reset press",   key_press,   '0);
        check_vec("mid reset release", key_release, '0);
        rst = 1'b0;
        c = cyc;
        push_exp(K_PRESS, 0, c, 0);
        wait_ms(40);
        check_bit("level after re-press", key_level[0], 1'b1);
        c2 = cyc;
        key_in[0] = 1'b0;
        push_exp(K_RELEASE, 0, c2, 0);
        wait_ms(40);
        check_events("reset held");

        n_cmp++;
        if (n_coin != 0) begin
            n_bad++;
            $display("FAIL press/release coincidence: got %0d cycles, required 0", n_coin);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_key_debounce
`default_nettype wire
